// File: rtl/conv2d_pkg.sv
// Shared types and default widths for the conv2d post-accumulator requantisation stage.
package conv2d_pkg;

  typedef enum logic [1:0] {
    ACT_IDENT    = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_RELU_CAP = 2'd2,
    ACT_LEAKY    = 2'd3
  } act_mode_e;

  localparam int DEF_NUM_CH  = 8;
  localparam int DEF_ACC_W   = 32;
  localparam int DEF_MULT_W  = 16;
  localparam int DEF_SHIFT_W = 6;
  localparam int DEF_OUT_W   = 8;
  localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/conv2d_requant_lane.sv
// One channel of the requant datapath: multiply (S1), rounding shift (S2), activation and
// saturation (S3). Load enables come from the shared valid/ready control in the top.
module conv2d_requant_lane
  import conv2d_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld1,
  input  logic                     ld2,
  input  logic                     ld3,
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [MULT_W-1:0] mult,
  input  logic [SHIFT_W-1:0]       shift1,
  input  logic [1:0]               mode2,
  input  logic [OUT_W-1:0]         cap2,
  output logic signed [OUT_W-1:0]  px,
  output logic                     sat
);

  localparam int PROD_W = ACC_W + MULT_W;
  // One guard bit so adding the rounding constant can never wrap.
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = (SUM_W'(1) <<< (OUT_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] MIN_V = -(SUM_W'(1) <<< (OUT_W - 1));

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [SUM_W-1:0]  sum, r_d, r_q, act, hi, lo, clamped;
  logic                     sat_d;
  int                       sh_eff;

  assign prod_d = PROD_W'(acc) * PROD_W'(mult);

  // Any shift >= PROD_W gives the same result as PROD_W, so clamping keeps SUM_W small.
  // NOTE: always_comb uses blocking assignments, and every variable gets a value before
  // any conditional path so no latch can be inferred.
  always_comb begin
    sh_eff = (int'(shift1) > PROD_W) ? PROD_W : int'(shift1);
    sum    = SUM_W'(prod_q);
    if (sh_eff != 0) sum = sum + (SUM_W'(1) <<< (sh_eff - 1));
    r_d    = sum >>> sh_eff;
  end

  always_comb begin
    act = r_q;
    hi  = MAX_V;
    lo  = MIN_V;
    case (act_mode_e'(mode2))
      ACT_RELU: begin
        lo = '0;
        if (r_q < 0) act = '0;
      end
      ACT_RELU_CAP: begin
        lo = '0;
        hi = SUM_W'(cap2);
        if (r_q < 0) act = '0;
      end
      ACT_LEAKY: begin
        if (r_q < 0) act = r_q >>> LEAKY_SHIFT;
      end
      default: ;
    endcase
    clamped = act;
    sat_d   = 1'b0;
    if (act > hi) begin
      clamped = hi;
      sat_d   = 1'b1;
    end else if (act < lo) begin
      clamped = lo;
      sat_d   = 1'b1;
    end
  end

  // NOTE: interior data registers carry no reset; the stage valids in the top decide
  // whether their contents mean anything. Only the visible output register is cleared.
  always_ff @(posedge clk) begin
    if (ld1) prod_q <= prod_d;
    if (ld2) r_q    <= r_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px  <= '0;
      sat <= 1'b0;
    end else if (ld3) begin
      px  <= OUT_W'(clamped);
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/conv2d_requant_act.sv
// Post-accumulator requant/activation stage: NUM_CH lanes behind a 3-stage valid/ready pipe
// whose per-stage enables let bubbles collapse and hold up to three beats under stall.
module conv2d_requant_act
  import conv2d_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MULT_W  = DEF_MULT_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*ACC_W-1:0]    in_acc_vec,
  input  logic [NUM_CH*MULT_W-1:0]   cfg_mult,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic [1:0]                 cfg_mode,
  input  logic [OUT_W-1:0]           cfg_cap,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_CH*OUT_W-1:0]    out_px_vec,
  output logic [NUM_CH-1:0]          out_sat
);

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic ld1, ld2, ld3;

  // Shared config travels alongside the beat so a change only affects later beats.
  logic [SHIFT_W-1:0] shift1;
  logic [1:0]         mode1, mode2;
  logic [OUT_W-1:0]   cap1, cap2;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1 && !rst;
  assign out_valid = v3;

  assign ld1 = in_valid && in_ready;
  assign ld2 = en2 && v1;
  assign ld3 = en3 && v2;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of the stage before it.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1) begin
      shift1 <= cfg_shift;
      mode1  <= cfg_mode;
      cap1   <= cfg_cap;
    end
    if (ld2) begin
      mode2 <= mode1;
      cap2  <= cap1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    conv2d_requant_lane #(
      .ACC_W  (ACC_W),
      .MULT_W (MULT_W),
      .SHIFT_W(SHIFT_W),
      .OUT_W  (OUT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .ld1   (ld1),
      .ld2   (ld2),
      .ld3   (ld3),
      .acc   (in_acc_vec[ch*ACC_W +: ACC_W]),
      .mult  (cfg_mult[ch*MULT_W +: MULT_W]),
      .shift1(shift1),
      .mode2 (mode2),
      .cap2  (cap2),
      .px    (out_px_vec[ch*OUT_W +: OUT_W]),
      .sat   (out_sat[ch])
    );
  end

endmodule

// File: tb/tb_conv2d_requant_act.sv
// Directed scoreboard bench for conv2d_requant_act: expected beats are queued on accept and
// compared on every output transfer.
module tb_conv2d_requant_act;

  localparam int NUM_CH  = 8;
  localparam int ACC_W   = 32;
  localparam int MULT_W  = 16;
  localparam int SHIFT_W = 6;
  localparam int OUT_W   = 8;
  localparam int MIN_INT = 32'sh8000_0000;

  typedef int vec8_t [NUM_CH];

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*ACC_W-1:0]  in_acc_vec;
  logic [NUM_CH*MULT_W-1:0] cfg_mult;
  logic [SHIFT_W-1:0]       cfg_shift;
  logic [1:0]               cfg_mode;
  logic [OUT_W-1:0]         cfg_cap;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*OUT_W-1:0]  out_px_vec;
  logic [NUM_CH-1:0]        out_sat;

  int total = 0;
  int bad   = 0;
  int n_sent = 0;
  int n_emit = 0;
  logic [71:0] sb_q [$];

  logic        prev_stalled = 1'b0;
  logic [63:0] prev_px;
  logic [7:0]  prev_sat;

  always #5 clk = ~clk;

  conv2d_requant_act dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc_vec(in_acc_vec),
    .cfg_mult  (cfg_mult),
    .cfg_shift (cfg_shift),
    .cfg_mode  (cfg_mode),
    .cfg_cap   (cfg_cap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_px_vec(out_px_vec),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact wide arithmetic, floor division for the leaky branch.
  function automatic logic [71:0] model(input vec8_t acc, input vec8_t mult, input int shift,
                                        input int mode, input int cap);
    logic signed [127:0] p, r, v, hi, lo;
    logic [63:0] px;
    logic [7:0]  s;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      p = acc[ch];
      p = p * mult[ch];
      if (shift == 0) r = p;
      else r = (p + (128'sd1 <<< (shift - 1))) >>> shift;
      v  = r;
      hi = 127;
      lo = -128;
      if (mode == 1 && r < 0) v = 0;
      if (mode == 2) begin
        hi = cap;
        if (r < 0) v = 0;
      end
      if (mode == 3 && r < 0) v = -((-r + 7) / 8);
      s[ch] = (v > hi) || (v < lo);
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      px[ch*OUT_W +: OUT_W] = v[7:0];
    end
    return {s, px};
  endfunction

  task automatic drive(input vec8_t acc, input vec8_t mult, input int shift, input int mode,
                       input int cap, input logic [71:0] exp);
    int n = 0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      in_acc_vec[ch*ACC_W +: ACC_W] = acc[ch];
      cfg_mult[ch*MULT_W +: MULT_W] = MULT_W'(mult[ch]);
    end
    cfg_shift = SHIFT_W'(shift);
    cfg_mode  = 2'(mode);
    cfg_cap   = OUT_W'(cap);
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 72'(in_ready), 72'd1);
    else begin
      sb_q.push_back(exp);
      n_sent++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_exp(input vec8_t acc, input vec8_t mult, input int shift, input int mode,
                          input int cap, input vec8_t epx, input vec8_t esat);
    logic [71:0] e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e[ch*OUT_W +: OUT_W] = OUT_W'(epx[ch]);
      e[64 + ch]           = esat[ch][0];
    end
    drive(acc, mult, shift, mode, cap, e);
  endtask

  task automatic send_model(input vec8_t acc, input vec8_t mult, input int shift, input int mode,
                            input int cap);
    drive(acc, mult, shift, mode, cap, model(acc, mult, shift, mode, cap));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 72'(sb_q.size()), 72'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_acc_vec = '0; cfg_mult = '0; cfg_shift = '0; cfg_mode = '0; cfg_cap = '0;

    // Output monitor: a transfer happens at the posedge following a negedge with valid & ready.
    fork
      forever begin
        logic [71:0] e;
        @(negedge clk);
        if (rst) prev_stalled = 1'b0;
        else begin
          if (out_valid && out_ready) begin
            if (sb_q.size() == 0) check("unexpected_beat", 72'(out_valid), 72'd0);
            else begin
              e = sb_q.pop_front();
              check("px", 72'(out_px_vec), 72'(e[63:0]));
              check("sat", 72'(out_sat), 72'(e[71:64]));
              n_emit++;
            end
          end
          if (out_valid && !out_ready) begin
            if (prev_stalled) begin
              check("stall_px_stable", 72'(out_px_vec), 72'(prev_px));
              check("stall_sat_stable", 72'(out_sat), 72'(prev_sat));
            end
            prev_stalled = 1'b1;
            prev_px      = out_px_vec;
            prev_sat     = out_sat;
          end else prev_stalled = 1'b0;
        end
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 72'(in_ready), 72'd0);
    check("rst_out_valid", 72'(out_valid), 72'd0);
    check("rst_out_px", 72'(out_px_vec), 72'd0);
    check("rst_out_sat", 72'(out_sat), 72'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 72'(in_ready), 72'd1);
    @(posedge clk);
    #1;

    // Directed beats, back to back.
    send_exp('{-5, 300, 42, 0, 127, 128, -128, -1000000}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 1, 0,
             '{0, 127, 42, 0, 127, 127, 0, 0}, '{0, 1, 0, 0, 0, 1, 0, 0});
    send_exp('{3, -3, 2, 1, -1, 0, 255, 257}, '{1, 1, 1, 1, 1, 1, 1, 1}, 1, 0, 0,
             '{2, -1, 1, 1, 0, 0, 127, 127}, '{0, 0, 0, 0, 0, 0, 1, 1});
    send_exp('{5, -5, 0, 1, 2, -2, 100, -200}, '{3, 3, 3, 3, 3, 3, 3, 3}, 2, 0, 0,
             '{4, -4, 0, 1, 2, -1, 75, -128}, '{0, 0, 0, 0, 0, 0, 0, 1});
    send_exp('{-200, 127, 128, -128, -129, 0, 1, -1}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 0, 0,
             '{-128, 127, 127, -128, -128, 0, 1, -1}, '{1, 0, 1, 0, 1, 0, 0, 0});
    send_exp('{10, 6, 7, 5, -3, 0, 1000, -1000}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 2, 6,
             '{6, 6, 6, 5, 0, 0, 6, 0}, '{1, 0, 1, 0, 0, 0, 1, 0});
    send_exp('{-16, -1, -8, -9, 100, 200, -1024, -1040}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 3, 0,
             '{-2, -1, -1, -2, 100, 127, -128, -128}, '{0, 0, 0, 0, 0, 1, 0, 1});
    send_exp('{10, 10, 10, 10, 10, 10, 10, 10}, '{1, 2, 3, 4, 5, 6, 7, 8}, 0, 0, 0,
             '{10, 20, 30, 40, 50, 60, 70, 80}, '{0, 0, 0, 0, 0, 0, 0, 0});
    send_exp('{2147483647, MIN_INT, 1, -1, 0, 1000, -1000, 5},
             '{32767, 32767, -32768, -32768, 5, -32768, -32768, 1}, 63, 0, 0,
             '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    send_exp('{2147483647, MIN_INT, 1073741824, -1073741824, 0, 0, 0, 0},
             '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767}, 40, 0, 0,
             '{64, -64, 32, -32, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
    send_exp('{MIN_INT, 2147483647, 1, -1, 0, 0, 0, 0},
             '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768}, 0, 0, 0,
             '{127, -128, -128, 127, 0, 0, 0, 0}, '{1, 1, 1, 1, 0, 0, 0, 0});
    // Scramble config while beats are in flight: it must not reach them.
    in_valid = 1'b0; cfg_mode = 2'd3; cfg_shift = 6'd63; cfg_cap = 8'd1;
    drain("directed_drain");

    // Backpressure: 20 ramp beats, out_ready low for cycles 5..14.
    @(posedge clk);
    #1;
    fork
      for (int k = 0; k < 20; k++) begin
        vec8_t a;
        for (int ch = 0; ch < NUM_CH; ch++) a[ch] = 37 * k - 300 + 11 * ch;
        send_model(a, '{1, -2, 3, -4, 5, -6, 7, -8}, 2, (k < 10) ? 3 : 2, 50);
        in_valid = 1'b0;
      end
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1 out_ready = !(c >= 5 && c <= 14);
        if (c == 10) begin
          @(negedge clk);
          check("bp_in_ready_low", 72'(in_ready), 72'd0);
          check("bp_out_valid_held", 72'(out_valid), 72'd1);
        end
      end
    join
    out_ready = 1'b1;
    drain("bp_drain");
    check("emit_count", 72'(n_emit), 72'(n_sent));

    // Reset with three beats in flight: all must be discarded.
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      send_model('{k, k, k, k, k, k, k, k}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    n_sent -= sb_q.size();
    sb_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 72'(in_ready), 72'd0);
    check("midrst_held_before", 72'(out_valid), 72'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 72'(out_valid), 72'd0);
    check("midrst_in_ready_after", 72'(in_ready), 72'd1);
    check("midrst_out_px", 72'(out_px_vec), 72'd0);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_emit", 72'(n_emit), 72'(n_sent));

    // Pipe still works after the mid-stream reset.
    @(posedge clk);
    #1;
    send_exp('{-5, 300, 42, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 1, 1, 1}, 0, 1, 0,
             '{0, 127, 42, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0, 0});
    in_valid = 1'b0;
    drain("final_drain");
    check("final_emit_count", 72'(n_emit), 72'(n_sent));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
